// File: rtl/icache_pkg.sv
// Shared constants, FSM state encoding and the CPU address split for the
// instruction-cache refill controller.
package icache_pkg;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int INDEX_W    = 7;
    localparam int LINE_WORDS = 8;
    localparam int OFFS_W     = 3;
    localparam int RAM_AW     = INDEX_W + OFFS_W;
    localparam int TAG_W      = ADDR_W - INDEX_W - OFFS_W - 2;
    localparam int LINES      = 1 << INDEX_W;

    // Controller states
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOOKUP   = 3'd1,
        MISS_REQ = 3'd2,
        REFILL   = 3'd3,
        RESP     = 3'd4
    } state_e;

    // Byte address viewed as tag / line index / word offset / byte offset
    typedef struct packed {
        logic [TAG_W-1:0]   tag;
        logic [INDEX_W-1:0] index;
        logic [OFFS_W-1:0]  offs;
        logic [1:0]         byte_offs;
    } addr_t;

    function automatic addr_t split_addr(input logic [ADDR_W-1:0] a);
        return addr_t'(a);
    endfunction

endpackage

// File: rtl/icache_tag_array.sv
// Tag and valid storage for the direct-mapped icache. Combinational read,
// single write port, and a clear-all of the valid bits (reset or invalidate).
module icache_tag_array
    import icache_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clr_all_i,
    input  logic [INDEX_W-1:0] rd_idx_i,
    output logic               rd_valid_o,
    output logic [TAG_W-1:0]   rd_tag_o,
    input  logic               wr_en_i,
    input  logic [INDEX_W-1:0] wr_idx_i,
    input  logic [TAG_W-1:0]   wr_tag_i,
    input  logic               wr_valid_i
);

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q [LINES];

    // Valid bits: clear-all wins over a same-cycle line write
    always_ff @(posedge clk) begin
        if (rst || clr_all_i) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_idx_i] <= wr_valid_i;
        end
    end

    // Tags need no reset; they are qualified by the valid bits
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_q[wr_idx_i] <= wr_tag_i;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];

endmodule

// File: rtl/icache_refill_ctrl.sv
// Direct-mapped icache controller: hit path reads the external data RAM,
// miss path fetches a full line from memory, writes it to the RAM and
// returns the critical word.
// Handshake: a request transfers on a cycle where cpu_req_valid && cpu_req_ready;
// mem_req transfers on mem_req_valid && mem_req_ready; cpu_rsp and mem_rsp
// are single-cycle pulses with no backpressure.
module icache_refill_ctrl
    import icache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req_valid,
    output logic              cpu_req_ready,
    input  logic [ADDR_W-1:0] cpu_req_addr,
    output logic              cpu_rsp_valid,
    output logic [DATA_W-1:0] cpu_rsp_data,
    input  logic              inv_all,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_data,
    output logic              ram_wr_en,
    output logic [RAM_AW-1:0] ram_wr_addr,
    output logic [DATA_W-1:0] ram_wr_data,
    output logic [RAM_AW-1:0] ram_rd_addr,
    input  logic [DATA_W-1:0] ram_rd_data
);

    state_e              state_q, state_d;
    addr_t               req_q;
    logic [OFFS_W-1:0]   beat_q;
    logic                inv_pend_q;
    logic [DATA_W-1:0]   crit_q;
    logic [RAM_AW-1:0]   rd_addr_q;

    addr_t               in_addr;
    logic                tag_valid;
    logic [TAG_W-1:0]    tag_rd;
    logic                hit;
    logic                accept;
    logic                beat;
    logic                last_beat;
    logic                unused_byte_offs;

    assign in_addr          = split_addr(cpu_req_addr);
    assign unused_byte_offs = ^{in_addr.byte_offs, req_q.byte_offs};

    icache_tag_array u_tags (
        .clk        (clk),
        .rst        (rst),
        .clr_all_i  (inv_all),
        .rd_idx_i   (req_q.index),
        .rd_valid_o (tag_valid),
        .rd_tag_o   (tag_rd),
        .wr_en_i    (last_beat),
        .wr_idx_i   (req_q.index),
        .wr_tag_i   (req_q.tag),
        .wr_valid_i (!(inv_pend_q || inv_all))
    );

    assign hit           = (state_q == LOOKUP) && tag_valid && (tag_rd == req_q.tag);
    assign cpu_req_ready = (state_q == IDLE) || hit;
    assign accept        = cpu_req_valid && cpu_req_ready;
    assign beat          = (state_q == REFILL) && mem_rsp_valid;
    assign last_beat     = beat && (beat_q == OFFS_W'(LINE_WORDS - 1));

    // Next-state selection
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (accept) state_d = LOOKUP;
            LOOKUP:   begin
                if (!hit)         state_d = MISS_REQ;
                else if (!accept) state_d = IDLE;
            end
            MISS_REQ: if (mem_req_ready) state_d = REFILL;
            REFILL:   if (last_beat) state_d = RESP;
            RESP:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // State, captured request, beat counter, critical word and invalidate tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            req_q      <= '0;
            beat_q     <= '0;
            inv_pend_q <= 1'b0;
            crit_q     <= '0;
            rd_addr_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                req_q     <= in_addr;
                rd_addr_q <= {in_addr.index, in_addr.offs};
            end
            if (state_q == MISS_REQ && mem_req_ready) begin
                beat_q <= '0;
            end else if (beat) begin
                beat_q <= beat_q + 1'b1;
            end
            if (beat && beat_q == req_q.offs) begin
                crit_q <= mem_rsp_data;
            end
            // A fill that overlaps an invalidate must not leave its line valid
            if (last_beat) begin
                inv_pend_q <= 1'b0;
            end else if (inv_all && (state_q == MISS_REQ || state_q == REFILL)) begin
                inv_pend_q <= 1'b1;
            end
        end
    end

    assign cpu_rsp_valid = hit || (state_q == RESP);
    assign cpu_rsp_data  = (state_q == RESP) ? crit_q :
                           hit               ? ram_rd_data : '0;

    assign mem_req_valid = (state_q == MISS_REQ);
    assign mem_req_addr  = mem_req_valid ? {req_q.tag, req_q.index, {OFFS_W{1'b0}}, 2'b00} : '0;

    assign ram_wr_en   = beat;
    assign ram_wr_addr = beat ? {req_q.index, beat_q} : '0;
    assign ram_wr_data = beat ? mem_rsp_data : '0;

    // Read address goes out in the accept cycle so the RAM data lands in LOOKUP
    assign ram_rd_addr = accept ? {in_addr.index, in_addr.offs} : rd_addr_q;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed bench for icache_refill_ctrl with a behavioural data RAM, a
// scripted memory responder and an in-order response scoreboard.
module tb_icache_refill_ctrl;
  import icache_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              cpu_req_valid;
  logic              cpu_req_ready;
  logic [ADDR_W-1:0] cpu_req_addr;
  logic              cpu_rsp_valid;
  logic [DATA_W-1:0] cpu_rsp_data;
  logic              inv_all;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_rsp_valid;
  logic [DATA_W-1:0] mem_rsp_data;
  logic              ram_wr_en;
  logic [RAM_AW-1:0] ram_wr_addr;
  logic [DATA_W-1:0] ram_wr_data;
  logic [RAM_AW-1:0] ram_rd_addr;
  logic [DATA_W-1:0] ram_rd_data;

  logic [31:0] exp_q[$];
  int checks = 0;
  int failures = 0;

  // clock / reset
  always #5 clk = ~clk;

  icache_refill_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .cpu_req_valid (cpu_req_valid),
    .cpu_req_ready (cpu_req_ready),
    .cpu_req_addr  (cpu_req_addr),
    .cpu_rsp_valid (cpu_rsp_valid),
    .cpu_rsp_data  (cpu_rsp_data),
    .inv_all       (inv_all),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .ram_wr_en     (ram_wr_en),
    .ram_wr_addr   (ram_wr_addr),
    .ram_wr_data   (ram_wr_data),
    .ram_rd_addr   (ram_rd_addr),
    .ram_rd_data   (ram_rd_data)
  );

  // 1024x32 simple dual-port RAM, one-cycle read latency
  logic [31:0] ram_mem [1024];
  always @(posedge clk) begin
    if (ram_wr_en) ram_mem[ram_wr_addr] <= ram_wr_data;
    ram_rd_data <= ram_mem[ram_rd_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // scoreboard monitor: every response must match the oldest expectation
  always @(negedge clk) begin
    if (!rst && cpu_rsp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rsp_unexpected actual=0x%08h required=none", cpu_rsp_data);
      end else begin
        check("rsp_data", cpu_rsp_data, exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // driver: present one request, optionally registering an expected response
  task automatic issue(input logic [31:0] a, input bit want_rsp, input logic [31:0] exp_data);
    int n = 0;
    while (!cpu_req_ready && n < 50) begin
      step();
      n++;
    end
    check("issue_ready", 32'(cpu_req_ready), 32'd1);
    if (want_rsp) exp_q.push_back(exp_data);
    cpu_req_valid = 1'b1;
    cpu_req_addr  = a;
    #1;
    check("ram_rd_addr", 32'(ram_rd_addr), 32'(a[11:2]));
    step();
    cpu_req_valid = 1'b0;
  endtask

  // driver: act as memory for one line fill
  task automatic serve_miss(input logic [31:0] line, input logic [3:0] gen,
                            input int stall, input int nbeats, input int inv_beat);
    int n = 0;
    while (!mem_req_valid && n < 20) begin
      step();
      n++;
    end
    check("mem_req_valid", 32'(mem_req_valid), 32'd1);
    check("mem_req_addr", mem_req_addr, line);
    check("miss_req_ready", 32'(cpu_req_ready), 32'd0);
    for (int s = 0; s < stall; s++) begin
      step();
      check("stall_req_valid", 32'(mem_req_valid), 32'd1);
      check("stall_req_addr", mem_req_addr, line);
      check("stall_cpu_ready", 32'(cpu_req_ready), 32'd0);
    end
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      logic [2:0] bb;
      bb = b[2:0];
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = {4'hD, gen, line[23:0] + 24'(b * 4)};
      inv_all       = (b == inv_beat);
      #1;
      check("ram_wr_en", 32'(ram_wr_en), 32'd1);
      check("ram_wr_addr", 32'(ram_wr_addr), 32'({line[11:5], bb}));
      check("ram_wr_data", ram_wr_data, mem_rsp_data);
      check("refill_cpu_ready", 32'(cpu_req_ready), 32'd0);
      step();
      mem_rsp_valid = 1'b0;
      inv_all       = 1'b0;
    end
    if (nbeats == LINE_WORDS) check("resp_after_last_beat", 32'(cpu_rsp_valid), 32'd1);
  endtask

  logic [31:0] hit_addr [3];

  initial begin
    rst = 1'b1;
    cpu_req_valid = 1'b0;
    cpu_req_addr  = '0;
    inv_all       = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    check("rst_cpu_req_ready", 32'(cpu_req_ready), 32'd1);
    check("rst_cpu_rsp_valid", 32'(cpu_rsp_valid), 32'd0);
    check("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
    check("rst_mem_req_addr", mem_req_addr, 32'd0);
    check("rst_ram_wr_en", 32'(ram_wr_en), 32'd0);
    check("rst_ram_rd_addr", 32'(ram_rd_addr), 32'd0);

    // cold miss, critical word 5
    issue(32'h0000_1014, 1'b1, 32'hD000_1014);
    serve_miss(32'h0000_1000, 4'h0, 0, 8, -1);

    // back-to-back hits on the freshly filled line
    hit_addr[0] = 32'h0000_1000;
    hit_addr[1] = 32'h0000_1004;
    hit_addr[2] = 32'h0000_1008;
    exp_q.push_back(32'hD000_1000);
    exp_q.push_back(32'hD000_1004);
    exp_q.push_back(32'hD000_1008);
    while (!cpu_req_ready) step();
    cpu_req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cpu_req_addr = hit_addr[i];
      step();
      check("b2b_hit_valid", 32'(cpu_rsp_valid), 32'd1);
      check("b2b_hit_no_mem", 32'(mem_req_valid), 32'd0);
    end
    cpu_req_valid = 1'b0;
    step();
    check("b2b_hit_end", 32'(cpu_rsp_valid), 32'd0);

    // conflict miss, then the evicted line misses again under a memory stall
    issue(32'h0000_2014, 1'b1, 32'hD000_2014);
    serve_miss(32'h0000_2000, 4'h0, 0, 8, -1);
    issue(32'h0000_1014, 1'b1, 32'hD100_1014);
    serve_miss(32'h0000_1000, 4'h1, 5, 8, -1);

    // invalidate during refill: word still delivered, line left invalid
    issue(32'h0000_3008, 1'b1, 32'hD000_3008);
    serve_miss(32'h0000_3000, 4'h0, 0, 8, 3);
    issue(32'h0000_3008, 1'b1, 32'hD100_3008);
    serve_miss(32'h0000_3000, 4'h1, 0, 8, -1);

    // second line at another index, then a single hit on it
    issue(32'h0000_0420, 1'b1, 32'hD000_0420);
    serve_miss(32'h0000_0420, 4'h0, 0, 8, -1);
    issue(32'h0000_0424, 1'b1, 32'hD000_0424);
    check("single_hit_valid", 32'(cpu_rsp_valid), 32'd1);
    check("single_hit_no_mem", 32'(mem_req_valid), 32'd0);

    // invalidate in IDLE: both lines miss afterwards
    while (!cpu_req_ready) step();
    step();
    inv_all = 1'b1;
    step();
    inv_all = 1'b0;
    issue(32'h0000_3008, 1'b1, 32'hD200_3008);
    serve_miss(32'h0000_3000, 4'h2, 0, 8, -1);
    issue(32'h0000_0420, 1'b1, 32'hD100_0420);
    serve_miss(32'h0000_0420, 4'h1, 0, 8, -1);

    // reset after three beats: no response, next fetch refills all 8 beats
    issue(32'h0000_5010, 1'b0, 32'h0);
    serve_miss(32'h0000_5000, 4'h0, 0, 3, -1);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("post_rst_no_rsp", 32'(cpu_rsp_valid), 32'd0);
      check("post_rst_no_mem", 32'(mem_req_valid), 32'd0);
      step();
    end
    issue(32'h0000_5010, 1'b1, 32'hD100_5010);
    serve_miss(32'h0000_5000, 4'h1, 0, 8, -1);

    repeat (4) step();
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
